// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider producing a registered square wave and a
// one-cycle tick per channel; new divisors are queued and applied at period boundaries.
module clock_divider_multi #(
    parameter  int NUM_CH         = 4,
    parameter  int WIDTH          = 16,
    parameter  int DEFAULT_DIVIDE = 10,
    localparam int CH_BITS        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_CH-1:0]  enable,
    input  logic               cfgWrite,
    input  logic [CH_BITS-1:0] cfgChannel,
    input  logic [WIDTH-1:0]   cfgDivide,
    output logic [NUM_CH-1:0]  cfgPending,
    output logic [NUM_CH-1:0]  clockOut,
    output logic [NUM_CH-1:0]  tick
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] pend_div;
        logic             pend_valid;
        logic             clk_q;
        logic             tick_q;

        logic             wr_hit;
        logic             running;
        logic             wrap;
        logic [WIDTH-1:0] cnt_next;
        logic [WIDTH-1:0] half;

        always_comb begin
            wr_hit   = cfgWrite && (cfgChannel == CH_BITS'(g));
            running  = enable[g] && (div != '0);
            wrap     = (cnt == div - WIDTH'(1));
            cnt_next = wrap ? '0 : cnt + WIDTH'(1);
            half     = div >> 1;
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                cnt        <= '0;
                div        <= WIDTH'(DEFAULT_DIVIDE);
                pend_div   <= '0;
                pend_valid <= 1'b0;
                clk_q      <= 1'b0;
                tick_q     <= 1'b0;
            end else begin
                if (running) begin
                    cnt    <= cnt_next;
                    tick_q <= wrap;
                    clk_q  <= (cnt_next != '0) && (cnt_next <= half);
                    // Queued divisor takes over on the same edge that emits the tick.
                    if (wrap && pend_valid) begin
                        div        <= pend_div;
                        pend_valid <= 1'b0;
                    end
                end else if (pend_valid) begin
                    div        <= pend_div;
                    cnt        <= '0;
                    clk_q      <= 1'b0;
                    tick_q     <= 1'b0;
                    pend_valid <= 1'b0;
                end else begin
                    tick_q <= 1'b0;
                end
                // A write on an apply edge becomes the next pending value.
                if (wr_hit) begin
                    pend_div   <= cfgDivide;
                    pend_valid <= 1'b1;
                end
            end
        end

        assign cfgPending[g] = pend_valid;
        assign clockOut[g]   = clk_q;
        assign tick[g]       = tick_q;
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: expected-value table, directed corner sequences and
// randomized traffic compared each cycle against an arithmetic reference model.
module tb_clock_divider_multi;

    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int DEF = 10;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [NCH-1:0] enable = '1;
    logic           cfgWrite = 1'b0;
    logic [1:0]     cfgChannel = '0;
    logic [W-1:0]   cfgDivide = '0;
    logic [NCH-1:0] cfgPending;
    logic [NCH-1:0] clockOut;
    logic [NCH-1:0] tick;

    // Second instance with NUM_CH=3 so an out-of-range channel number is representable.
    logic [2:0]     en3 = 3'b111;
    logic           wr3 = 1'b0;
    logic [1:0]     ch3 = '0;
    logic [W-1:0]   div3 = '0;
    logic [2:0]     pend3;
    logic [2:0]     clk3;
    logic [2:0]     tick3;

    clock_divider_multi #(.NUM_CH(NCH), .WIDTH(W), .DEFAULT_DIVIDE(DEF)) dut (
        .clock(clock), .reset(reset), .enable(enable), .cfgWrite(cfgWrite),
        .cfgChannel(cfgChannel), .cfgDivide(cfgDivide), .cfgPending(cfgPending),
        .clockOut(clockOut), .tick(tick)
    );

    clock_divider_multi #(.NUM_CH(3), .WIDTH(W), .DEFAULT_DIVIDE(DEF)) dut3 (
        .clock(clock), .reset(reset), .enable(en3), .cfgWrite(wr3),
        .cfgChannel(ch3), .cfgDivide(div3), .cfgPending(pend3),
        .clockOut(clk3), .tick(tick3)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int e_cnt = 0;

    // Reference model: phase counter advances modulo the divisor.
    int             m_cnt [NCH];
    int             m_div [NCH];
    int             m_pdv [NCH];
    bit             m_pv  [NCH];
    logic [NCH-1:0] x_clk;
    logic [NCH-1:0] x_tick;
    logic [NCH-1:0] x_pend;

    typedef struct {
        int             edge_n;
        logic [NCH-1:0] en;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] clk;
        logic [NCH-1:0] pend;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e_cnt, act, exp);
        end
    endtask

    function automatic void model_edge();
        if (!reset) begin
            for (int ch = 0; ch < NCH; ch++) begin
                m_cnt[ch] = 0;
                m_div[ch] = DEF;
                m_pv[ch]  = 1'b0;
                x_clk[ch]  = 1'b0;
                x_tick[ch] = 1'b0;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                bit wr;
                wr = cfgWrite && (int'(cfgChannel) == ch);
                if (enable[ch] && m_div[ch] != 0) begin
                    int c;
                    c = (m_cnt[ch] + 1) % m_div[ch];
                    x_tick[ch] = (c == 0);
                    x_clk[ch]  = (c != 0) && (c <= m_div[ch] / 2);
                    m_cnt[ch]  = c;
                    if (c == 0 && m_pv[ch]) begin
                        m_div[ch] = m_pdv[ch];
                        m_pv[ch]  = 1'b0;
                    end
                end else if (m_pv[ch]) begin
                    m_div[ch]  = m_pdv[ch];
                    m_pv[ch]   = 1'b0;
                    m_cnt[ch]  = 0;
                    x_clk[ch]  = 1'b0;
                    x_tick[ch] = 1'b0;
                end else begin
                    x_tick[ch] = 1'b0;
                end
                if (wr) begin
                    m_pdv[ch] = int'(cfgDivide);
                    m_pv[ch]  = 1'b1;
                end
            end
        end
        for (int ch = 0; ch < NCH; ch++) x_pend[ch] = m_pv[ch];
    endfunction

    task automatic step();
        @(posedge clock);
        model_edge();
        e_cnt++;
        #1;
        check("model cfgPending", 32'(cfgPending), 32'(x_pend));
        check("model clockOut", 32'(clockOut), 32'(x_clk));
        check("model tick", 32'(tick), 32'(x_tick));
    endtask

    task automatic run_to(input int e);
        while (e_cnt < e) step();
    endtask

    task automatic write_cfg(input int ch, input int d);
        cfgWrite   = 1'b1;
        cfgChannel = 2'(ch);
        cfgDivide  = W'(d);
        step();
        cfgWrite   = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        step();
        reset = 1'b1;
        e_cnt = 0;
    endtask

    task automatic run_table();
        for (int i = 0; i < 13; i++) begin
            enable = tbl[i].en;
            run_to(tbl[i].edge_n);
            check("table tick", 32'(tick), 32'(tbl[i].tick));
            check("table clockOut", 32'(clockOut), 32'(tbl[i].clk));
            check("table cfgPending", 32'(cfgPending), 32'(tbl[i].pend));
        end
    endtask

    initial begin
        tbl[0]  = '{1,  4'hF, 4'h0, 4'hF, 4'h0};
        tbl[1]  = '{2,  4'hF, 4'h0, 4'hF, 4'h0};
        tbl[2]  = '{5,  4'hF, 4'h0, 4'hF, 4'h0};
        tbl[3]  = '{6,  4'hF, 4'h0, 4'h0, 4'h0};
        tbl[4]  = '{9,  4'hF, 4'h0, 4'h0, 4'h0};
        tbl[5]  = '{10, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[6]  = '{11, 4'hF, 4'h0, 4'hF, 4'h0};
        tbl[7]  = '{15, 4'hF, 4'h0, 4'hF, 4'h0};
        tbl[8]  = '{16, 4'hF, 4'h0, 4'h0, 4'h0};
        tbl[9]  = '{20, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[10] = '{25, 4'hF, 4'h0, 4'hF, 4'h0};
        tbl[11] = '{26, 4'hF, 4'h0, 4'h0, 4'h0};
        tbl[12] = '{30, 4'hF, 4'hF, 4'h0, 4'h0};

        // Reset state and default-divisor timing.
        reset = 1'b0;
        repeat (3) step();
        check("reset cfgPending", 32'(cfgPending), 32'h0);
        check("reset clockOut", 32'(clockOut), 32'h0);
        check("reset tick", 32'(tick), 32'h0);
        reset = 1'b1;
        e_cnt = 0;
        run_table();

        // ch1 divisor 3 queued mid-period; out-of-range write on the 3-channel instance.
        reset_pulse();
        run_to(3);
        wr3 = 1'b1; ch3 = 2'd3; div3 = W'(2);
        write_cfg(1, 3);
        wr3 = 1'b0;
        check("s2 pending set", 32'(cfgPending[1]), 32'h1);
        check("oob write ignored", 32'(pend3), 32'h0);
        run_to(9);
        check("s2 pending held", 32'(cfgPending[1]), 32'h1);
        step();
        check("s2 wrap all tick", 32'(tick), 32'hF);
        check("s2 pending cleared", 32'(cfgPending[1]), 32'h0);
        check("oob default tick", 32'(tick3), 32'h7);
        step();
        check("s2 clk c=1", 32'(clockOut[1]), 32'h1);
        step();
        check("s2 clk c=2", 32'(clockOut[1]), 32'h0);
        check("oob no early tick", 32'(tick3), 32'h0);
        step();
        check("s2 tick 13", 32'(tick[1]), 32'h1);
        run_to(15);
        check("s2 no tick 15", 32'(tick[1]), 32'h0);
        step();
        check("s2 tick 16", 32'(tick[1]), 32'h1);
        run_to(20);
        check("s2 ch0 tick 20", 32'(tick[0]), 32'h1);

        // ch2: divisor 1 via the stopped path, then divisor 0.
        enable[2] = 1'b0;
        step();
        write_cfg(2, 1);
        check("s3 pending while off", 32'(cfgPending[2]), 32'h1);
        step();
        check("s3 applied while off", 32'(cfgPending[2]), 32'h0);
        enable[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("s3 D=1 tick", 32'(tick[2]), 32'h1);
            check("s3 D=1 clk", 32'(clockOut[2]), 32'h0);
        end
        write_cfg(2, 0);
        check("s3 D=0 pending", 32'(cfgPending[2]), 32'h1);
        step();
        check("s3 D=0 applied", 32'(cfgPending[2]), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("s3 stopped tick", 32'(tick[2]), 32'h0);
        end

        // ch0 paused at cnt=7 for five cycles.
        run_to(37);
        enable[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("s4 frozen tick", 32'(tick[0]), 32'h0);
            check("s4 frozen clk", 32'(clockOut[0]), 32'h0);
        end
        enable[0] = 1'b1;
        step();
        check("s4 resume 1", 32'(tick[0]), 32'h0);
        step();
        check("s4 resume 2", 32'(tick[0]), 32'h0);
        step();
        check("s4 resume tick", 32'(tick[0]), 32'h1);

        // ch3: overwrite before wrap, write coinciding with wrap.
        run_to(51);
        write_cfg(3, 4);
        run_to(54);
        write_cfg(3, 6);
        run_to(59);
        write_cfg(3, 8);
        check("s5 wrap tick", 32'(tick[3]), 32'h1);
        check("s5 pending kept", 32'(cfgPending[3]), 32'h1);
        run_to(64);
        check("s5 no D=4 tick", 32'(tick[3]), 32'h0);
        run_to(66);
        check("s5 D=6 tick", 32'(tick[3]), 32'h1);
        check("s5 D=8 applied", 32'(cfgPending[3]), 32'h0);
        run_to(72);
        check("s5 no early tick", 32'(tick[3]), 32'h0);
        run_to(74);
        check("s5 D=8 tick", 32'(tick[3]), 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 199) != 0);
            enable     = 4'($urandom);
            cfgWrite   = ($urandom_range(0, 3) == 0);
            cfgChannel = 2'($urandom);
            cfgDivide  = W'($urandom_range(0, 7));
            step();
        end
        cfgWrite = 1'b0;
        enable   = '1;
        reset    = 1'b1;

        // Reset mid-period with a queued divisor on ch0.
        reset_pulse();
        run_to(3);
        write_cfg(0, 5);
        check("s6 pending before reset", 32'(cfgPending[0]), 32'h1);
        run_to(6);
        reset = 1'b0;
        step();
        check("s6 reset pending", 32'(cfgPending), 32'h0);
        check("s6 reset clockOut", 32'(clockOut), 32'h0);
        check("s6 reset tick", 32'(tick), 32'h0);
        reset = 1'b1;
        e_cnt = 0;
        run_table();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
